// File: rtl/ej32_boot_mem.sv
// Byte-wide unified program/data SRAM with a boot copier that streams a ROM image
// into SRAM after reset, then serves core byte reads/writes with one-cycle read latency.
module ej32_boot_mem #(
    parameter int unsigned ASZ    = 17,
    parameter int unsigned ROM_SZ = 'h1000,
    parameter int unsigned DST    = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [ASZ-1:0] ai,
    input  logic [7:0]     vi,
    input  logic           we,
    output logic [7:0]     vo,
    output logic [ASZ-1:0] rom_a,
    input  logic [7:0]     rom_d,
    output logic           rom_en,
    output logic           boot_done
);

    typedef enum logic [1:0] {COPY, DRAIN, RUN} state_t;

    localparam logic [ASZ:0]   LAST  = (ASZ+1)'(ROM_SZ - 1);
    localparam logic [ASZ-1:0] DST_A = ASZ'(DST);

    state_t         state;
    state_t         state_nx;
    logic [ASZ:0]   cnt;
    logic           wv;
    logic [ASZ-1:0] wa;
    logic [7:0]     mem [0:(1<<ASZ)-1];

    always_comb begin
        state_nx = state;
        case (state)
            COPY:    if (cnt == LAST) state_nx = DRAIN;
            DRAIN:   state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign rom_en = (state != RUN) && !rst;
    assign rom_a  = (state == COPY) ? cnt[ASZ-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= COPY;
        else     state <= state_nx;
    end

    // wv/wa delay the write by one cycle to line up with the synchronous ROM's data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            wv        <= 1'b0;
            vo        <= '0;
            boot_done <= 1'b0;
        end else begin
            case (state)
                COPY: begin
                    wv  <= 1'b1;
                    wa  <= cnt[ASZ-1:0];
                    cnt <= cnt + (ASZ+1)'(1);
                    vo  <= '0;
                end
                DRAIN: begin
                    wv        <= 1'b0;
                    boot_done <= 1'b1;
                    vo        <= '0;
                end
                default: vo <= we ? vi : mem[ai];
            endcase
        end
    end

    // Destination address wraps naturally at the ASZ-bit width.
    always_ff @(posedge clk) begin
        if (wv)
            mem[DST_A + wa] <= rom_d;
        else if (state == RUN && we && !rst)
            mem[ai] <= vi;
    end

endmodule

// File: tb/tb_ej32_boot_mem.sv
// Self-checking bench for ej32_boot_mem: behavioural model on the main instance,
// plus literal checks of boot length, wrap-around destination and a one-byte ROM.
module tb_ej32_boot_mem;

    localparam int RSZ = 16;
    localparam int AW  = 17;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic          rst_a, we_a, en_a, done_a;
    logic [AW-1:0] ai_a, ra_a;
    logic [7:0]    vi_a, vo_a, rd_a;
    logic          rst_b, we_b, en_b, done_b;
    logic [AW-1:0] ai_b, ra_b;
    logic [7:0]    vi_b, vo_b, rd_b;
    logic          rst_c, we_c, en_c, done_c;
    logic [AW-1:0] ai_c, ra_c;
    logic [7:0]    vi_c, vo_c, rd_c;

    ej32_boot_mem #(.ASZ(AW), .ROM_SZ(RSZ), .DST(0)) dut_a (
        .clk(clk), .rst(rst_a), .ai(ai_a), .vi(vi_a), .we(we_a), .vo(vo_a),
        .rom_a(ra_a), .rom_d(rd_a), .rom_en(en_a), .boot_done(done_a));

    ej32_boot_mem #(.ASZ(AW), .ROM_SZ(8), .DST((1 << AW) - 4)) dut_b (
        .clk(clk), .rst(rst_b), .ai(ai_b), .vi(vi_b), .we(we_b), .vo(vo_b),
        .rom_a(ra_b), .rom_d(rd_b), .rom_en(en_b), .boot_done(done_b));

    ej32_boot_mem #(.ASZ(AW), .ROM_SZ(1), .DST(5)) dut_c (
        .clk(clk), .rst(rst_c), .ai(ai_c), .vi(vi_c), .we(we_c), .vo(vo_c),
        .rom_a(ra_c), .rom_d(rd_c), .rom_en(en_c), .boot_done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROMs holding ROM[n] = A0 + n.
    always @(posedge clk) begin
        rd_a <= 8'hA0 + ra_a[7:0];
        rd_b <= 8'hA0 + ra_b[7:0];
        rd_c <= 8'hA0 + ra_c[7:0];
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model of instance A: k counts cycles since the last reset edge.
    int         k = 0;
    bit         mvalid = 0;
    logic [7:0] exp_vo = '0;
    bit         vo_known = 0;
    logic [7:0] mem_m [int];

    always @(posedge clk) begin
        if (rst_a) begin
            k = 0; mvalid = 1; exp_vo = '0; vo_known = 1;
        end else if (mvalid) begin
            if (k < RSZ) begin
                mem_m[k] = 8'hA0 + 8'(k);
                exp_vo = '0; vo_known = 1;
            end else if (k == RSZ) begin
                exp_vo = '0; vo_known = 1;
            end else if (we_a) begin
                mem_m[int'(ai_a)] = vi_a;
                exp_vo = vi_a; vo_known = 1;
            end else if (mem_m.exists(int'(ai_a))) begin
                exp_vo = mem_m[int'(ai_a)]; vo_known = 1;
            end else begin
                vo_known = 0;
            end
            if (k <= RSZ) k++;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("rom_en", en_a, !rst_a && (k <= RSZ));
            check("rom_a", ra_a, (k < RSZ) ? k : 0);
            check("boot_done", done_a, k > RSZ);
            if (vo_known) check("vo", vo_a, exp_vo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic measure_a(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!en_a) break;
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        rst_a = 1; we_a = 0; ai_a = '0; vi_a = '0;
        rst_b = 1; we_b = 0; ai_b = '0; vi_b = '0;
        rst_c = 1; we_c = 0; ai_c = '0; vi_c = '0;
        tick(); tick();
        check("reset_rom_en", en_a, 0);
        check("reset_done", done_a, 0);
        check("reset_vo", vo_a, 0);

        // Boot with core writes attempted throughout the copy.
        we_a = 1; ai_a = 17'd3; vi_a = 8'h55; rst_a = 0;
        measure_a(n);
        check("copy_len", n, RSZ + 1);
        check("done_at_fall", done_a, 1);
        we_a = 0;
        for (int i = 0; i < RSZ; i++) begin
            ai_a = AW'(i);
            tick();
            check("boot_rd", vo_a, 8'hA0 + i);
        end

        // Back-to-back write then reads.
        we_a = 1; ai_a = 17'd100; vi_a = 8'h3C;
        tick(); check("wr_through", vo_a, 8'h3C);
        we_a = 0;
        tick(); check("rd100", vo_a, 8'h3C);
        ai_a = 17'd15;
        tick(); check("rd15", vo_a, 8'hAF);

        we_a = 1; ai_a = 17'd200; vi_a = 8'h77;
        tick();
        for (int i = 0; i < 300; i++) begin
            we_a = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       ai_a = AW'($urandom_range(0, 15));
                1:       ai_a = 17'd100;
                2:       ai_a = AW'($urandom_range(300, 307));
                default: ai_a = AW'($urandom_range(201, 203));
            endcase
            vi_a = 8'($urandom);
            tick();
        end

        // Reset from RUN, then a second reset when cnt reaches 9.
        we_a = 0; rst_a = 1;
        tick();
        rst_a = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (ra_a == 17'd9) begin found = 1; break; end
            tick();
        end
        check("reach_cnt9", found, 1);
        rst_a = 1;
        #1 check("en_in_rst", en_a, 0);
        tick();
        rst_a = 0;
        #1 check("restart_a0", ra_a, 0);
        measure_a(n);
        check("recopy_len", n, RSZ + 1);
        ai_a = 17'd200;
        tick(); check("keep200", vo_a, 8'h77);
        ai_a = 17'd3;
        tick(); check("recopy3", vo_a, 8'hA3);

        // Wrapping destination.
        rst_b = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_b) begin found = 1; break; end
            tick();
        end
        check("b_done", found, 1);
        for (int i = 0; i < 8; i++) begin
            ai_b = AW'((1 << AW) - 4 + i);
            tick();
            check("b_wrap_rd", vo_b, 8'hA0 + i);
        end

        // Single-byte ROM.
        rst_c = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!en_c) break;
            n++;
            tick();
        end
        check("c_len", n, 2);
        check("c_done", done_c, 1);
        ai_c = 17'd5;
        tick(); check("c_rd", vo_c, 8'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
